// File: rtl/i2c_rx_bit_counter_n.sv
// I2C receive-side bit counter and shift register.
// A transfer is started with Start. The block then assembles bytes from SDA,
// which is sampled on each DecCount edge. It counts completed bytes up to the
// target that was captured at Start, and flags a sticky Overrun when a sample
// arrives while no byte is being shifted.
module i2c_rx_bit_counter_n #(
  parameter int DATA_BITS = 8,
  parameter int MAX_BYTES = 16,
  parameter int MSB_FIRST = 1,
  localparam int CW = $clog2(DATA_BITS),
  localparam int BW = $clog2(MAX_BYTES + 1)
) (
  input  logic                 SCL,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [BW-1:0]        ByteTarget,
  input  logic                 LoadBitCount,
  input  logic                 DecCount,
  input  logic                 SDA,
  output logic [CW-1:0]        RxBitCount,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 DataValid,
  output logic [BW-1:0]        ByteCount,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Overrun
);

  typedef enum logic [1:0] {IDLE, SHIFT, ACK, DONE} stateT;

  localparam logic [CW-1:0] BIT_TOP  = CW'(DATA_BITS - 1);
  localparam logic [BW-1:0] MAX_TGT  = BW'(MAX_BYTES);

  stateT                state, nextState;
  logic [DATA_BITS-1:0] shiftReg, nextShift, shifted;
  logic [CW-1:0]        nextBitCount;
  logic [DATA_BITS-1:0] nextData;
  logic                 nextValid;
  logic [BW-1:0]        target, nextTarget;
  logic [BW-1:0]        nextByteCount, byteCountInc;
  logic                 nextOverrun;
  logic                 nextBusy, nextDone;

  // State register; reset always parks the FSM in IDLE
  always_ff @(posedge SCL or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state and datapath decode; Start overrides everything else
  always_comb begin
    nextState     = state;
    nextShift     = shiftReg;
    nextBitCount  = RxBitCount;
    nextData      = RxData;
    nextValid     = 1'b0;
    nextTarget    = target;
    nextByteCount = ByteCount;
    nextOverrun   = Overrun;
    byteCountInc  = ByteCount + BW'(1);
    if (MSB_FIRST != 0) shifted = {shiftReg[DATA_BITS-2:0], SDA};
    else                shifted = {SDA, shiftReg[DATA_BITS-1:1]};

    if (Start) begin
      nextTarget    = (ByteTarget > MAX_TGT) ? MAX_TGT : ByteTarget;
      nextByteCount = '0;
      nextOverrun   = 1'b0;
      nextShift     = '0;
      nextBitCount  = BIT_TOP;
      nextState     = (ByteTarget == '0) ? DONE : SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          if (LoadBitCount) begin
            nextShift    = '0;
            nextBitCount = BIT_TOP;
          end else if (DecCount) begin
            nextShift = shifted;
            if (RxBitCount != '0) begin
              nextBitCount = RxBitCount - CW'(1);
            end else begin
              nextData      = shifted;
              nextValid     = 1'b1;
              nextByteCount = byteCountInc;
              nextState     = (byteCountInc == target) ? DONE : ACK;
            end
          end
        end
        ACK: begin
          if (LoadBitCount) begin
            nextShift    = '0;
            nextBitCount = BIT_TOP;
            nextState    = SHIFT;
          end else if (DecCount) begin
            nextOverrun = 1'b1;
          end
        end
        DONE: begin
          if (DecCount && !LoadBitCount) nextOverrun = 1'b1;
        end
        default: ;
      endcase
    end

    nextBusy = (nextState == SHIFT) || (nextState == ACK);
    nextDone = (nextState == DONE);
  end

  // Datapath and status registers, all updated on SCL rising edge
  always_ff @(posedge SCL or negedge Reset) begin
    if (!Reset) begin
      shiftReg   <= '0;
      RxBitCount <= BIT_TOP;
      RxData     <= '0;
      DataValid  <= 1'b0;
      target     <= '0;
      ByteCount  <= '0;
      Overrun    <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      shiftReg   <= nextShift;
      RxBitCount <= nextBitCount;
      RxData     <= nextData;
      DataValid  <= nextValid;
      target     <= nextTarget;
      ByteCount  <= nextByteCount;
      Overrun    <= nextOverrun;
      Busy       <= nextBusy;
      Done       <= nextDone;
    end
  end

endmodule

// File: tb/tb_i2c_rx_bit_counter_n.sv
// Directed bench for i2c_rx_bit_counter_n. A scoreboard queue holds the
// expected bytes and pops them whenever DataValid pulses. A second instance
// with MSB_FIRST=0 shares the same stimulus so that bit ordering can be compared.
module tb_i2c_rx_bit_counter_n;

  logic       scl = 1'b0;
  logic       resetN = 1'b1;
  logic       start = 1'b0;
  logic [4:0] byteTarget = '0;
  logic       loadBitCount = 1'b0;
  logic       decCount = 1'b0;
  logic       sda = 1'b0;

  logic [2:0] rxBitCount, rxBitCountLsb;
  logic [7:0] rxData, rxDataLsb;
  logic       dataValid, dataValidLsb;
  logic [4:0] byteCount, byteCountLsb;
  logic       busy, busyLsb, done, doneLsb, overrun, overrunLsb;

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ[$];

  i2c_rx_bit_counter_n #(.DATA_BITS(8), .MAX_BYTES(16), .MSB_FIRST(1)) dut (
    .SCL(scl), .Reset(resetN), .Start(start), .ByteTarget(byteTarget),
    .LoadBitCount(loadBitCount), .DecCount(decCount), .SDA(sda),
    .RxBitCount(rxBitCount), .RxData(rxData), .DataValid(dataValid),
    .ByteCount(byteCount), .Busy(busy), .Done(done), .Overrun(overrun)
  );

  i2c_rx_bit_counter_n #(.DATA_BITS(8), .MAX_BYTES(16), .MSB_FIRST(0)) dutLsb (
    .SCL(scl), .Reset(resetN), .Start(start), .ByteTarget(byteTarget),
    .LoadBitCount(loadBitCount), .DecCount(decCount), .SDA(sda),
    .RxBitCount(rxBitCountLsb), .RxData(rxDataLsb), .DataValid(dataValidLsb),
    .ByteCount(byteCountLsb), .Busy(busyLsb), .Done(doneLsb), .Overrun(overrunLsb)
  );

  // Free-running SCL, rising edges at 5, 15, 25, ...
  always #5 scl = ~scl;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1ns later and service the scoreboard
  task automatic clockStep();
    @(posedge scl);
    #1;
    if (dataValid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL sb_unexpected observed=%0h expected=none", rxData);
      end else begin
        checkOutput("sb_rxData", {24'h0, rxData}, {24'h0, expQ.pop_front()});
      end
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [4:0] tgt, input logic ld,
                               input logic dc, input logic d);
    start = st; byteTarget = tgt; loadBitCount = ld; decCount = dc; sda = d;
    clockStep();
    start = 1'b0; loadBitCount = 1'b0; decCount = 1'b0;
  endtask

  // Shift one byte MSB first, checking the bit counter before every sample
  task automatic sendByte(input logic [7:0] b);
    expQ.push_back(b);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("bitCount_bit%0d", i), {29'h0, rxBitCount}, 32'(7 - i));
      applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, b[7-i]);
    end
    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    $display("[TB] start");
    #2 resetN = 1'b0;
    #1;
    checkOutput("rst_bitCount", {29'h0, rxBitCount}, 32'd7);
    checkOutput("rst_rxData", {24'h0, rxData}, 32'h0);
    checkOutput("rst_flags", {28'h0, dataValid, busy, done, overrun}, 32'h0);
    checkOutput("rst_byteCount", {27'h0, byteCount}, 32'd0);
    @(posedge scl);
    @(posedge scl);
    #1 resetN = 1'b1;

    // Samples in IDLE are ignored
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    checkOutput("idle_ignore", {25'h0, rxBitCount, busy, overrun, 2'b0}, {25'h0, 3'd7, 4'b0});

    // Single byte A5
    applyStimulus(1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("start_busy", {30'h0, busy, done}, 32'b10);
    sendByte(8'hA5);
    checkOutput("a5_valid", {31'h0, dataValid}, 32'd1);
    checkOutput("a5_byteCount", {27'h0, byteCount}, 32'd1);
    checkOutput("a5_doneBusy", {30'h0, done, busy}, 32'b10);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("a5_validPulse", {31'h0, dataValid}, 32'd0);
    checkOutput("done_ignoreLoad", {28'h0, done, rxBitCount}, {28'h0, 1'b1, 3'd0});
    checkOutput("a5_holdData", {24'h0, rxData}, 32'hA5);

    // Two bytes with overrun in ACK
    applyStimulus(1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    sendByte(8'h3C);
    checkOutput("ack_state", {27'h0, byteCount}, 32'd1);
    checkOutput("ack_busy", {30'h0, busy, done}, 32'b10);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("ovr_set", {31'h0, overrun}, 32'd1);
    checkOutput("ovr_hold", {16'h0, rxData, byteCount, rxBitCount}, {16'h0, 8'h3C, 5'd1, 3'd0});
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("ack_reload", {28'h0, busy, rxBitCount}, {28'h0, 1'b1, 3'd7});
    sendByte(8'hFF);
    checkOutput("ff_done", {25'h0, done, busy, byteCount}, {25'h0, 2'b10, 5'd2});
    checkOutput("ovr_sticky", {31'h0, overrun}, 32'd1);
    applyStimulus(1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("ovr_clear", {31'h0, overrun}, 32'd0);

    // Asynchronous reset after three bits
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("pre_rst_bitCount", {29'h0, rxBitCount}, 32'd4);
    #2 resetN = 1'b0;
    #1;
    checkOutput("async_rst", {17'h0, rxBitCount, rxData, byteCount, busy, done},
                {17'h0, 3'd7, 8'hA5 & 8'h00, 5'd0, 2'b00});
    @(posedge scl);
    #1 resetN = 1'b1;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("post_rst_ignore", {27'h0, busy, rxBitCount, 1'b0}, {27'h0, 1'b0, 3'd7, 1'b0});

    // Zero target goes straight to DONE
    applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("zero_target", {30'h0, done, busy}, 32'b10);

    // Load plus sample mid-byte discards the partial byte
    applyStimulus(1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("mid_bitCount", {29'h0, rxBitCount}, 32'd4);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    checkOutput("discard_bitCount", {29'h0, rxBitCount}, 32'd7);
    sendByte(8'h5A);
    checkOutput("discard_done", {30'h0, done, dataValid}, 32'b11);

    // Bit ordering: same SDA stream into both instances
    applyStimulus(1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    sendByte(8'hC0);
    checkOutput("msb_first", {24'h0, rxData}, 32'hC0);
    checkOutput("lsb_first", {24'h0, rxDataLsb}, 32'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/i2c_rx_bit_counter_n.md
I2C_RX_BIT_COUNTER_N -- requirements
Module: i2c_rx_bit_counter_n

Interface
REQ-001 The module SHALL have parameter DATA_BITS, default 8, setting bits per received byte (legal range 2..32).
REQ-002 The module SHALL have parameter MAX_BYTES, default 16, setting the largest byte count per transfer (legal range 1..255).
REQ-003 The module SHALL have parameter MSB_FIRST, default 1: 1 = first sampled bit lands in RxData MSB; 0 = first sampled bit lands in LSB.
REQ-004 The module SHALL derive local widths CW = clog2(DATA_BITS) and BW = clog2(MAX_BYTES+1).
REQ-005 The module SHALL have port SCL, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port Start, input, 1 bit: begin a transfer; captures ByteTarget.
REQ-008 The module SHALL have port ByteTarget, input, BW bits: number of bytes to receive.
REQ-009 The module SHALL have port LoadBitCount, input, 1 bit: reload the bit counter for the next byte.
REQ-010 The module SHALL have port DecCount, input, 1 bit: sample SDA and decrement the bit counter.
REQ-011 The module SHALL have port SDA, input, 1 bit: serial data, sampled only when DecCount=1.
REQ-012 The module SHALL have outputs RxBitCount (CW), RxData (DATA_BITS), DataValid (1), ByteCount (BW), Busy (1), Done (1) and Overrun (1), all registered.

Function
REQ-013 The FSM SHALL have four states: IDLE, SHIFT, ACK and DONE. Busy=1 in SHIFT and ACK; Done=1 only in DONE.
REQ-014 Start in any state SHALL have top priority: capture ByteTarget, clear ByteCount, clear Overrun, clear the shift register, set RxBitCount=DATA_BITS-1, and go to SHIFT. If ByteTarget=0, go to DONE instead.
REQ-015 In SHIFT, DecCount SHALL shift SDA into the shift register per MSB_FIRST. If RxBitCount>0, RxBitCount decrements by 1.
REQ-016 In SHIFT, DecCount with RxBitCount=0 SHALL:
- load RxData with the completed byte, including the current bit, on the same edge;
- pulse DataValid high for exactly one cycle;
- increment ByteCount;
- go to DONE if the new ByteCount equals the captured target, else go to ACK.
REQ-017 In SHIFT, LoadBitCount (with or without DecCount) SHALL discard the partial byte, clear the shift register and set RxBitCount=DATA_BITS-1. LoadBitCount wins over DecCount.
REQ-018 In ACK, LoadBitCount SHALL set RxBitCount=DATA_BITS-1, clear the shift register and go to SHIFT.
REQ-019 In ACK or DONE, DecCount without LoadBitCount SHALL set sticky Overrun=1 and leave all counters and data unchanged.
REQ-020 In IDLE, LoadBitCount and DecCount SHALL be ignored.
REQ-021 In DONE, LoadBitCount SHALL be ignored; only Start or Reset leaves DONE.
REQ-022 RxData SHALL hold its last value until the next byte completes. ByteCount SHALL never exceed the captured target, and never wraps.
REQ-023 RxBitCount SHALL never wrap below 0.

Reset
REQ-024 Reset=0 SHALL immediately, independent of SCL, force: state IDLE, RxBitCount=DATA_BITS-1, shift register=0, RxData=0, DataValid=0, ByteCount=0, Busy=0, Done=0, Overrun=0.
REQ-025 Reset deasserted mid-transfer SHALL leave the block in IDLE; a new Start is required to receive.

Verification (DATA_BITS=8, MAX_BYTES=16 unless stated)
REQ-026 Start with ByteTarget=1, then 8 DecCount with SDA=1,0,1,0,0,1,0,1 -> RxBitCount 7..0, RxData=8'hA5, DataValid high one cycle on the 8th edge, ByteCount=1, Done=1.
REQ-027 ByteTarget=2: receive 8'h3C, LoadBitCount in ACK, then receive 8'hFF -> two DataValid pulses, Busy=1 until the second byte, then Done=1 and ByteCount=2.
REQ-028 DecCount in ACK -> Overrun=1, RxBitCount/ByteCount/RxData unchanged; the next Start clears Overrun.
REQ-029 Reset asserted between SCL edges after 3 bits -> all outputs at reset values before the next edge; after release, DecCount is ignored.
REQ-030 MSB_FIRST=0, SDA=1,1,0,0,0,0,0,0 -> RxData=8'h03 (MSB_FIRST=1 gives 8'hC0).
REQ-031 Start with ByteTarget=0 -> Done=1 and Busy=0 next cycle; LoadBitCount+DecCount together at RxBitCount=4 in SHIFT -> RxBitCount=7, partial byte discarded.
